// File: rtl/spi_mem_slave.sv
// SPI mode-0 slave that bridges read (0x03), write (0x02) and status (0x05) commands to one SRAM client port.
// Optional feature: define SPI_MEM_WREN_EN so that 0x02 is accepted only while the write-enable latch (WEL) is set.
module spi_mem_slave #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_begin_rd,
  output logic              mem_begin_wr,
  input  logic              mem_finish,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data_wr,
  input  logic [7:0]        mem_data_rd
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, STATUS, IGNORE} state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;

  state_t            state_q, state_d;
  logic [1:0]        cs_sync, sclk_sync, mosi_sync;
  logic              cs_prev, sclk_prev;
  logic              cs_s, sclk_s, mosi_s;
  logic              cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [4:0]        bit_cnt;
  logic [7:0]        rx_sr, tx_sr, rx_byte;
  logic [ADDR_W-1:0] ptr, addr_next;
  logic              wr_mode, outstanding, wel;
  logic              data_state, byte_done, cmd_done, addr_done;
  logic              issue_rd, issue_wr, status_load, miso_shift, cnt_wrap;

  // NOTE: sequential blocks use non-blocking (<=) only, so every flop sees pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      cs_prev   <= 1'b1;
      sclk_sync <= 2'b00;
      sclk_prev <= 1'b0;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs};
      sclk_sync <= {sclk_sync[0], spi_sclk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_prev   <= cs_sync[1];
      sclk_prev <= sclk_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_rise = ~cs_s & sclk_s & ~sclk_prev;
  assign sclk_fall = ~cs_s & ~sclk_s & sclk_prev;
  assign rx_byte   = {rx_sr[6:0], mosi_s};
  assign addr_next = {ptr[ADDR_W-2:0], mosi_s};

`ifdef SPI_MEM_WREN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wel <= 1'b0;
    end else if (cs_rise && wr_mode) begin
      wel <= 1'b0;
    end else if (cmd_done && rx_byte == CMD_WREN) begin
      wel <= 1'b1;
    end else if (cmd_done && rx_byte == CMD_WRDI) begin
      wel <= 1'b0;
    end
  end
`else
  assign wel = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else if (cs_fall) begin
      state_d = CMD;
    end else if (sclk_rise) begin
      case (state_q)
        CMD: begin
          if (bit_cnt == 5'd7) begin
            case (rx_byte)
              CMD_READ:  state_d = ADDR;
              CMD_WRITE: state_d = wel ? ADDR : IGNORE;
              CMD_RDSR:  state_d = STATUS;
              default:   state_d = IGNORE;
            endcase
          end
        end
        ADDR:    if (bit_cnt == 5'd23) state_d = wr_mode ? WRITE : READ;
        default: ;
      endcase
    end
  end

  always_comb begin
    data_state  = (state_q == READ) || (state_q == WRITE) || (state_q == STATUS);
    byte_done   = sclk_rise && (bit_cnt[2:0] == 3'd7);
    cmd_done    = (state_q == CMD) && byte_done;
    addr_done   = (state_q == ADDR) && sclk_rise && (bit_cnt == 5'd23);
    issue_rd    = ~outstanding && ((addr_done && ~wr_mode) || ((state_q == READ) && byte_done));
    issue_wr    = (state_q == WRITE) && byte_done;
    status_load = (cmd_done && rx_byte == CMD_RDSR) || ((state_q == STATUS) && byte_done);
    miso_shift  = sclk_fall && ((state_q == READ) || (state_q == STATUS));
    cnt_wrap    = cmd_done || addr_done || (data_state && byte_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_begin_rd <= 1'b0;
      mem_begin_wr <= 1'b0;
      mem_addr     <= '0;
      mem_data_wr  <= '0;
      spi_miso     <= 1'b0;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      ptr          <= '0;
      wr_mode      <= 1'b0;
      outstanding  <= 1'b0;
    end else begin
      mem_begin_rd <= issue_rd;
      mem_begin_wr <= issue_wr;

      if (cs_fall)        bit_cnt <= '0;
      else if (sclk_rise) bit_cnt <= cnt_wrap ? 5'd0 : bit_cnt + 5'd1;

      if (sclk_rise) rx_sr <= rx_byte;

      if (cs_fall || cs_rise) wr_mode <= 1'b0;
      else if (cmd_done)      wr_mode <= (rx_byte == CMD_WRITE) && wel;

      // The address shifts straight into the pointer; only the low ADDR_W of the 24 bits survive.
      if ((state_q == ADDR) && sclk_rise)                             ptr <= addr_next;
      else if (((state_q == READ) || (state_q == WRITE)) && byte_done) ptr <= ptr + 1'b1;

      // Address/data registers move only with a begin pulse, so they hold between requests.
      if (issue_rd) begin
        mem_addr <= (state_q == ADDR) ? addr_next : ptr + 1'b1;
      end else if (issue_wr) begin
        mem_addr    <= ptr;
        mem_data_wr <= rx_byte;
      end

      if (issue_rd)        outstanding <= 1'b1;
      else if (mem_finish) outstanding <= 1'b0;

      if (cs_rise)         spi_miso <= 1'b0;
      else if (miso_shift) spi_miso <= tx_sr[7];

      // A finish with nothing outstanding (e.g. one that straddled a reset) is dropped.
      if (mem_finish && outstanding) tx_sr <= mem_data_rd;
      else if (status_load)          tx_sr <= {6'b0, wel, 1'b0};
      else if (miso_shift)           tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: SPI host tasks, SRAM client responder, immediate-assertion checks.
// Expectations follow the build: define SPI_MEM_WREN_EN here too when the RTL is built with it.
module tb_spi_mem_slave;

  localparam int ADDR_W = 20;
  localparam int HALF   = 100;  // sclk half period: 10 clk cycles

`ifdef SPI_MEM_WREN_EN
  localparam bit WREN_EN = 1'b1;
`else
  localparam bit WREN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              spi_cs, spi_sclk, spi_mosi, spi_miso;
  logic              mem_begin_rd, mem_begin_wr, mem_finish;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data_wr, mem_data_rd;

  int n_asserts = 0;
  int n_fail    = 0;
  int finish_delay = 2;

  logic [ADDR_W-1:0]   rd_log[$];
  logic [ADDR_W+7:0]   wr_log[$];
  int                  collisions = 0;
  int                  miso_high_cnt = 0;

  always #5 clk = ~clk;

  spi_mem_slave #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .mem_begin_rd(mem_begin_rd),
    .mem_begin_wr(mem_begin_wr),
    .mem_finish  (mem_finish),
    .mem_addr    (mem_addr),
    .mem_data_wr (mem_data_wr),
    .mem_data_rd (mem_data_rd)
  );

  function automatic logic [7:0] mem_model(input logic [ADDR_W-1:0] a);
    case (a)
      20'h00123: return 8'hA5;
      20'h00124: return 8'h3C;
      20'hFFFFF: return 8'h11;
      20'h00000: return 8'h22;
      default:   return 8'h00;
    endcase
  endfunction

  // Request monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_begin_rd) rd_log.push_back(mem_addr);
    if (mem_begin_wr) wr_log.push_back({mem_addr, mem_data_wr});
    if (mem_begin_rd && mem_begin_wr) collisions++;
    if (spi_miso !== 1'b0) miso_high_cnt++;
  end

  // SRAM client responder: finish pulse finish_delay cycles after each begin_rd.
  initial begin
    logic [ADDR_W-1:0] a;
    mem_finish  = 1'b0;
    mem_data_rd = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_begin_rd) begin
        a = mem_addr;
        repeat (finish_delay) @(negedge clk);
        mem_data_rd = mem_model(a);
        mem_finish  = 1'b1;
        @(negedge clk);
        mem_finish  = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      #HALF spi_sclk = 1'b1;
      rx = {rx[6:0], spi_miso};
      #HALF spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] dummy;
    spi_xfer(tx, 8, dummy);
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    #HALF spi_cs = 1'b1;
    #(4 * HALF);
  endtask

  task automatic read_status(output logic [7:0] rx);
    cs_begin();
    spi_byte(8'h05);
    spi_xfer(8'h00, 8, rx);
    cs_end();
  endtask

  task automatic one_cmd(input logic [7:0] c);
    cs_begin();
    spi_byte(c);
    cs_end();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx0, rx1;
    int rb, wb, mh;

    reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_begin_rd", 32'(mem_begin_rd), 32'h0);
    check("rst_begin_wr", 32'(mem_begin_wr), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_data_wr", 32'(mem_data_wr), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_miso", 32'(spi_miso), 32'h0);

    // Read 0x00123 with two dummy bytes.
    rb = rd_log.size();
    cs_begin();
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h01); spi_byte(8'h23);
    spi_xfer(8'h00, 8, rx0);
    spi_xfer(8'h00, 8, rx1);
    cs_end();
    check("rd_byte0", 32'(rx0), 32'hA5);
    check("rd_byte1", 32'(rx1), 32'h3C);
    check("rd_addr0", 32'(rd_log[rb]), 32'h00123);
    check("rd_addr1", 32'(rd_log[rb+1]), 32'h00124);
    check("rd_addr2", 32'(rd_log[rb+2]), 32'h00125);
    check("rd_count", 32'(rd_log.size() - rb), 32'd3);
    check("rd_miso_after_cs", 32'(spi_miso), 32'h0);

    // WREN, then write two bytes at 0x00010.
    wb = wr_log.size();
    one_cmd(8'h06);
    cs_begin();
    spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
    spi_byte(8'h55); spi_byte(8'hAA);
    cs_end();
    check("wr_count", 32'(wr_log.size() - wb), 32'd2);
    check("wr_0", 32'(wr_log[wb]), {4'h0, 20'h00010, 8'h55});
    check("wr_1", 32'(wr_log[wb+1]), {4'h0, 20'h00011, 8'hAA});
    check("wr_addr_held", 32'(mem_addr), 32'h00011);
    check("wr_data_held", 32'(mem_data_wr), 32'hAA);
    read_status(rx0);
    check("status_after_write", 32'(rx0), WREN_EN ? 32'h00 : 32'h02);

    // Write without WREN, then WEL set/clear through status.
    wb = wr_log.size();
    cs_begin();
    spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10); spi_byte(8'h55);
    cs_end();
    check("wr_no_wren_count", 32'(wr_log.size() - wb), WREN_EN ? 32'd0 : 32'd1);
    read_status(rx0);
    check("status_no_wren", 32'(rx0), WREN_EN ? 32'h00 : 32'h02);
    one_cmd(8'h06);
    cs_begin();
    spi_byte(8'h05);
    spi_xfer(8'h00, 8, rx0);
    spi_xfer(8'h00, 8, rx1);
    cs_end();
    check("status_wren_b0", 32'(rx0), 32'h02);
    check("status_wren_b1", 32'(rx1), 32'h02);
    one_cmd(8'h04);
    read_status(rx0);
    check("status_wrdi", 32'(rx0), WREN_EN ? 32'h00 : 32'h02);

    // Read across the top of the address space.
    rb = rd_log.size();
    cs_begin();
    spi_byte(8'h03); spi_byte(8'h0F); spi_byte(8'hFF); spi_byte(8'hFF);
    spi_xfer(8'h00, 8, rx0);
    spi_xfer(8'h00, 8, rx1);
    cs_end();
    check("wrap_addr0", 32'(rd_log[rb]), 32'hFFFFF);
    check("wrap_addr1", 32'(rd_log[rb+1]), 32'h00000);
    check("wrap_byte0", 32'(rx0), 32'h11);
    check("wrap_byte1", 32'(rx1), 32'h22);

    // cs rises mid data byte: nothing written.
    one_cmd(8'h06);
    wb = wr_log.size();
    cs_begin();
    spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h20);
    spi_xfer(8'hF0, 4, rx0);
    cs_end();
    check("partial_wr_count", 32'(wr_log.size() - wb), 32'd0);
    check("partial_miso", 32'(spi_miso), 32'h0);
    read_status(rx0);
    check("partial_then_status", 32'(rx0), WREN_EN ? 32'h00 : 32'h02);

    // Reset between begin_rd and a late mem_finish.
    finish_delay = 30;
    rb = rd_log.size();
    cs_begin();
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h01); spi_byte(8'h23);
    check("abort_rd_issued", 32'(rd_log.size() - rb), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    spi_cs = 1'b1;
    check("abort_rst_miso", 32'(spi_miso), 32'h0);
    check("abort_rst_begin_rd", 32'(mem_begin_rd), 32'h0);
    check("abort_rst_begin_wr", 32'(mem_begin_wr), 32'h0);
    check("abort_rst_addr", 32'(mem_addr), 32'h0);
    check("abort_rst_data_wr", 32'(mem_data_wr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mh = miso_high_cnt;
    repeat (40) @(negedge clk);
    check("abort_late_finish_miso", 32'(miso_high_cnt - mh), 32'd0);
    check("abort_no_more_rd", 32'(rd_log.size() - rb), 32'd1);
    check("abort_addr_kept", 32'(mem_addr), 32'h0);
    finish_delay = 2;

    // Recovery: a fresh read after the aborted one.
    cs_begin();
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h01); spi_byte(8'h24);
    spi_xfer(8'h00, 8, rx0);
    cs_end();
    check("recover_byte", 32'(rx0), 32'h3C);
    check("no_rd_wr_collision", 32'(collisions), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
